// File: rtl/torus_link_buffered.sv
// 2-D torus fabric: every directed neighbour link is a LINK_DEPTH-entry FIFO with
// valid/ready on both ends, so no combinational path crosses the fabric.
module torus_link_buffered #(
  parameter int H_SIZE     = 3,
  parameter int V_SIZE     = 3,
  parameter int DATA_WIDTH = 37,
  parameter int LINK_DEPTH = 2,
  parameter int NODES_NUM  = H_SIZE * V_SIZE,
  parameter int PORT_SIZE  = DATA_WIDTH + 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NODES_NUM*4*PORT_SIZE-1:0] data_i,
  output logic [NODES_NUM*4*PORT_SIZE-1:0] data_o,
  output logic [NODES_NUM*4-1:0]           link_full
);

  // Handshake: a flit moves when valid and ready are both high at a rising edge.
  // Bundle = {ready, valid, data}. Fabric ready on data_o(k) is !full of the FIFO fed by
  // data_i(k); valid/data on data_o(k) come from the FIFO whose link ends at slot k.

  localparam int NL = NODES_NUM * 4;
  localparam int AW = (LINK_DEPTH > 1) ? $clog2(LINK_DEPTH) : 1;
  localparam int CW = $clog2(LINK_DEPTH) + 1;

  // Node reached from node n through port d (0=E, 1=S, 2=W, 3=N), with torus wrap.
  function automatic int neighbour(input int n, input int d);
    int r;
    int c;
    r = n / H_SIZE;
    c = n % H_SIZE;
    case (d)
      0:       return r * H_SIZE + (c + 1) % H_SIZE;
      1:       return ((r + 1) % V_SIZE) * H_SIZE + c;
      2:       return r * H_SIZE + (c + H_SIZE - 1) % H_SIZE;
      default: return ((r + V_SIZE - 1) % V_SIZE) * H_SIZE + c;
    endcase
  endfunction

  logic [DATA_WIDTH-1:0] head_w   [NL];
  logic                  nempty_w [NL];
  logic                  full_w   [NL];

  for (genvar l = 0; l < NL; l++) begin : g_link
    localparam int DST = neighbour(l / 4, l % 4) * 4 + ((l % 4) + 2) % 4;

    logic [DATA_WIDTH-1:0] mem_q [LINK_DEPTH];
    logic [AW-1:0]         wptr_q, wptr_d;
    logic [AW-1:0]         rptr_q, rptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  push;
    logic                  pop;

    // Fabric ready is only !full: a pop in the same cycle cannot make room.
    assign push = data_i[l*PORT_SIZE+DATA_WIDTH] && !full_w[l];
    assign pop  = nempty_w[l] && data_i[DST*PORT_SIZE+DATA_WIDTH+1];

    always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        wptr_q <= wptr_d;
        rptr_q <= rptr_d;
        cnt_q  <= cnt_d;
      end
    end

    always_ff @(posedge clk) begin
      if (push && !rst) mem_q[wptr_q] <= data_i[l*PORT_SIZE +: DATA_WIDTH];
    end

    assign full_w[l]   = (cnt_q == CW'(LINK_DEPTH));
    assign nempty_w[l] = (cnt_q != '0);
    assign head_w[l]   = mem_q[rptr_q];
  end

  for (genvar j = 0; j < NL; j++) begin : g_slot
    // Sender feeding slot j sits in direction (j%4) and uses the opposite port.
    localparam int SRC = neighbour(j / 4, j % 4) * 4 + ((j % 4) + 2) % 4;

    logic                  vld;
    assign vld = !rst && nempty_w[SRC];

    assign data_o[j*PORT_SIZE +: PORT_SIZE] = {
      !rst && !full_w[j],
      vld,
      vld ? head_w[SRC] : {DATA_WIDTH{1'b0}}
    };
    assign link_full[j] = !rst && full_w[j];
  end

endmodule
